// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types and constants for the logic-unit arbiter slice:
// logic select encodings, FIFO depth, condition-code layout and the LZC helper.
package logic_unit_arbiter_pkg;

    typedef enum logic [2:0] {
        LOG_SEL_GEN  = 3'b000,
        LOG_SEL_AND  = 3'b001,
        LOG_SEL_OR   = 3'b010,
        LOG_SEL_NOT  = 3'b011,
        LOG_SEL_XOR  = 3'b100,
        LOG_SEL_PAR  = 3'b101,
        LOG_SEL_LZC  = 3'b110,
        LOG_SEL_SEXT = 3'b111
    } log_sel_e;

    localparam int unsigned LOG_FIFO_DEPTH = 2;
    localparam int unsigned LOG_CC_ZERO    = 0;

    // Datapath part of a FIFO entry; src/tag widths are per-instance.
    typedef struct packed {
        logic [31:0] rslt;
        logic [1:0]  cc;
    } log_rslt_t;

    // Leading-zero count; an all-zero input returns all ones.
    function automatic logic [31:0] log_lzc(input logic [31:0] v);
        logic [31:0] n;
        logic        found;
        n     = 32'hFFFF_FFFF;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!found && v[31-i]) begin
                n     = i;
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/Logic.sv
// Combinational integer logic unit: operand-B select, eight logic functions
// and the {1'b0, zero} condition code.
module Logic
    import logic_unit_arbiter_pkg::*;
(
    input  logic [31:0] i_opr0,
    input  logic [31:0] i_opr1,
    input  logic [15:0] i_imm16,
    input  logic [11:0] i_gen,
    input  logic [2:0]  i_sel,
    input  logic        i_rsel,
    output logic [31:0] o_rslt,
    output logic [1:0]  o_cc
);

    logic [31:0] w_oprb;

    assign w_oprb = i_rsel ? {16'h0000, i_imm16} : i_opr1;

    always_comb begin
        o_rslt = '0;
        case (i_sel)
            LOG_SEL_GEN:  o_rslt = {20'h0, i_gen};
            LOG_SEL_AND:  o_rslt = i_opr0 & w_oprb;
            LOG_SEL_OR:   o_rslt = i_opr0 | w_oprb;
            LOG_SEL_NOT:  o_rslt = ~i_opr0;
            LOG_SEL_XOR:  o_rslt = i_opr0 ^ w_oprb;
            LOG_SEL_PAR:  o_rslt = {31'h0, ^i_opr0};
            LOG_SEL_LZC:  o_rslt = log_lzc(i_opr0);
            LOG_SEL_SEXT: o_rslt = {{16{w_oprb[15]}}, w_oprb[15:0]};
            default:      o_rslt = '0;
        endcase
    end

    always_comb begin
        o_cc              = '0;
        o_cc[LOG_CC_ZERO] = (o_rslt == '0);
    end

endmodule

// File: rtl/logic_unit_arbiter_rr.sv
// Round-robin picker: first valid index searching cyclically from i_ptr,
// gated by i_en.
module logic_unit_arbiter_rr #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_vld,
    input  logic [SRC_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_gnt,
    output logic [SRC_W-1:0] o_idx,
    output logic             o_any
);

    int unsigned w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_j = 32'(i_ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (i_en && !o_any && i_vld[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = SRC_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one Logic unit among NREQ requesters with round-robin grant and a
// 2-entry result FIFO. Optional perf counters: define LOGIC_ARB_PERF_CNT_EN.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk_i_lar,
    input  logic                    rst_n_i_lar,
    input  logic [NREQ-1:0]         req_vld_i_lar,
    output logic [NREQ-1:0]         req_rdy_o_lar,
    input  logic [NREQ*32-1:0]      req_opr0_i_lar,
    input  logic [NREQ*32-1:0]      req_opr1_i_lar,
    input  logic [NREQ*16-1:0]      req_imm16_i_lar,
    input  logic [NREQ*12-1:0]      req_gen_i_lar,
    input  logic [NREQ*3-1:0]       req_sel_i_lar,
    input  logic [NREQ-1:0]         req_rsel_i_lar,
    input  logic [NREQ*TAG_W-1:0]   req_tag_i_lar,
    output logic                    rslt_vld_o_lar,
    input  logic                    rslt_rdy_i_lar,
    output logic [31:0]             rslt_o_lar,
    output logic [1:0]              rslt_cc_o_lar,
    output logic [SRC_W-1:0]        rslt_src_o_lar,
    output logic [TAG_W-1:0]        rslt_tag_o_lar,
    output logic                    busy_o_lar
`ifdef LOGIC_ARB_PERF_CNT_EN
    ,
    output logic [NREQ*16-1:0]      grant_cnt_o_lar,
    output logic [15:0]             stall_cnt_o_lar
`endif
);

    typedef struct packed {
        log_rslt_t        res;
        logic [SRC_W-1:0] src;
        logic [TAG_W-1:0] tag;
    } fifo_entry_t;

    fifo_entry_t      r_mem [LOG_FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic [SRC_W-1:0] r_ptr;

    logic             w_issue_en;
    logic [NREQ-1:0]  w_gnt;
    logic [SRC_W-1:0] w_idx;
    logic             w_any;
    logic             w_pop;
    logic [31:0]      w_rslt;
    logic [1:0]       w_cc;
    fifo_entry_t      w_entry;
    fifo_entry_t      w_head;

    // Issue uses the registered count only, so req_rdy never sees rslt_rdy.
    assign w_issue_en = (r_cnt < 2'(LOG_FIFO_DEPTH));
    assign w_pop      = (r_cnt != 2'd0) && rslt_rdy_i_lar;

    logic_unit_arbiter_rr #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_rr (
        .i_vld (req_vld_i_lar),
        .i_ptr (r_ptr),
        .i_en  (w_issue_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    Logic u_logic (
        .i_opr0  (req_opr0_i_lar[32'(w_idx)*32 +: 32]),
        .i_opr1  (req_opr1_i_lar[32'(w_idx)*32 +: 32]),
        .i_imm16 (req_imm16_i_lar[32'(w_idx)*16 +: 16]),
        .i_gen   (req_gen_i_lar[32'(w_idx)*12 +: 12]),
        .i_sel   (req_sel_i_lar[32'(w_idx)*3 +: 3]),
        .i_rsel  (req_rsel_i_lar[w_idx]),
        .o_rslt  (w_rslt),
        .o_cc    (w_cc)
    );

    always_comb begin
        w_entry          = '0;
        w_entry.res.rslt = w_rslt;
        w_entry.res.cc   = w_cc;
        w_entry.src      = w_idx;
        w_entry.tag      = req_tag_i_lar[32'(w_idx)*TAG_W +: TAG_W];
    end

    always_ff @(posedge clk_i_lar or negedge rst_n_i_lar) begin
        if (!rst_n_i_lar) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_ptr    <= '0;
        end else begin
            if (w_any) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
                r_ptr           <= (32'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_any, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign req_rdy_o_lar  = w_gnt;
    assign rslt_vld_o_lar = (r_cnt != 2'd0);
    assign rslt_o_lar     = w_head.res.rslt;
    assign rslt_cc_o_lar  = w_head.res.cc;
    assign rslt_src_o_lar = w_head.src;
    assign rslt_tag_o_lar = w_head.tag;
    assign busy_o_lar     = (r_cnt != 2'd0) || (|req_vld_i_lar);

`ifdef LOGIC_ARB_PERF_CNT_EN
    logic [15:0] r_gnt_cnt [NREQ];
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i_lar or negedge rst_n_i_lar) begin
        if (!rst_n_i_lar) begin
            r_gnt_cnt   <= '{default: '0};
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_gnt_cnt[i] != '1)) begin
                    r_gnt_cnt[i] <= r_gnt_cnt[i] + 16'd1;
                end
            end
            if ((|req_vld_i_lar) && !w_issue_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt_o_lar = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt_o_lar[i*16 +: 16] = r_gnt_cnt[i];
        end
    end

    assign stall_cnt_o_lar = r_stall_cnt;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (NREQ=2, TAG_W=4).
module tb_logic_unit_arbiter;
    import logic_unit_arbiter_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned SRC_W = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*32-1:0]    req_opr0;
    logic [NREQ*32-1:0]    req_opr1;
    logic [NREQ*16-1:0]    req_imm16;
    logic [NREQ*12-1:0]    req_gen;
    logic [NREQ*3-1:0]     req_sel;
    logic [NREQ-1:0]       req_rsel;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic                  rslt_vld;
    logic                  rslt_rdy;
    logic [31:0]           rslt;
    logic [1:0]            rslt_cc;
    logic [SRC_W-1:0]      rslt_src;
    logic [TAG_W-1:0]      rslt_tag;
    logic                  busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) dut (
        .clk_i_lar       (clk),
        .rst_n_i_lar     (rst_n),
        .req_vld_i_lar   (req_vld),
        .req_rdy_o_lar   (req_rdy),
        .req_opr0_i_lar  (req_opr0),
        .req_opr1_i_lar  (req_opr1),
        .req_imm16_i_lar (req_imm16),
        .req_gen_i_lar   (req_gen),
        .req_sel_i_lar   (req_sel),
        .req_rsel_i_lar  (req_rsel),
        .req_tag_i_lar   (req_tag),
        .rslt_vld_o_lar  (rslt_vld),
        .rslt_rdy_i_lar  (rslt_rdy),
        .rslt_o_lar      (rslt),
        .rslt_cc_o_lar   (rslt_cc),
        .rslt_src_o_lar  (rslt_src),
        .rslt_tag_o_lar  (rslt_tag),
        .busy_o_lar      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string nm, input int unsigned src, input logic [3:0] tag,
                              input logic [31:0] r, input logic [1:0] cc);
        check({nm, "_vld"},  32'(rslt_vld), 32'd1);
        check({nm, "_rslt"}, rslt, r);
        check({nm, "_cc"},   32'(rslt_cc), 32'(cc));
        check({nm, "_src"},  32'(rslt_src), src);
        check({nm, "_tag"},  32'(rslt_tag), 32'(tag));
    endtask

    task automatic set_req(input int unsigned i, input logic vld, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                           input logic rsel, input logic [3:0] tag);
        req_vld[i]           = vld;
        req_sel[i*3 +: 3]    = sel;
        req_opr0[i*32 +: 32] = a;
        req_opr1[i*32 +: 32] = b;
        req_imm16[i*16 +: 16] = imm;
        req_rsel[i]          = rsel;
        req_tag[i*4 +: 4]    = tag;
        req_gen[i*12 +: 12]  = 12'hABC;
    endtask

    task automatic do_single(input string nm, input int unsigned idx, input logic [2:0] sel,
                             input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                             input logic rsel, input logic [3:0] tag,
                             input logic [31:0] exp, input logic [1:0] exp_cc);
        @(negedge clk);
        set_req(idx, 1'b1, sel, a, b, imm, rsel, tag);
        #1 check({nm, "_rdy"}, 32'(req_rdy), 32'(1 << idx));
        @(negedge clk);
        req_vld[idx] = 1'b0;
        #1 check_head(nm, idx, tag, exp, exp_cc);
    endtask

    initial begin
        int unsigned g;
        rst_n     = 1'b0;
        rslt_rdy  = 1'b1;
        req_vld   = '0;
        req_opr0  = '0;
        req_opr1  = '0;
        req_imm16 = '0;
        req_gen   = '0;
        req_sel   = '0;
        req_rsel  = '0;
        req_tag   = '0;

        #2;
        check("rst_vld",  32'(rslt_vld), 32'd0);
        check("rst_rslt", rslt, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy",  32'(req_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single AND with one-cycle latency
        @(negedge clk);
        set_req(0, 1'b1, LOG_SEL_AND, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 16'h0, 1'b0, 4'd3);
        #1 check("and_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
        req_vld = '0;
        #1 check_head("and", 0, 4'd3, 32'h00F0_F0F0, 2'b00);

        // Both valid continuously, consumer ready: ptr is 1 after the AND grant
        @(negedge clk);
        set_req(0, 1'b1, LOG_SEL_XOR, 32'h0000_FFFF, 32'h00FF_00FF, 16'h0, 1'b0, 4'hA);
        set_req(1, 1'b1, LOG_SEL_NOT, 32'hFFFF_FFFF, 32'h0, 16'h0, 1'b0, 4'hB);
        for (int k = 0; k < 5; k++) begin
            #1;
            g = (k % 2 == 0) ? 1 : 0;
            check("alt_rdy", 32'(req_rdy), 32'(1 << g));
            if (k > 0) begin
                if (g == 1) check_head("alt", 0, 4'hA, 32'h00FF_FF00, 2'b00);
                else        check_head("alt", 1, 4'hB, 32'h0, 2'b01);
            end
            @(negedge clk);
        end
        req_vld = '0;
        #1 check_head("alt_last", 1, 4'hB, 32'h0, 2'b01);

        // Backpressure: two accepted, then stall with head stable
        @(negedge clk);
        rslt_rdy = 1'b0;
        set_req(0, 1'b1, LOG_SEL_AND, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 16'h0, 1'b0, 4'd1);
        set_req(1, 1'b1, LOG_SEL_LZC, 32'h0001_0000, 32'h0, 16'h0, 1'b0, 4'd2);
        #1 check("bp_rdy0", 32'(req_rdy), 32'd1);
        @(negedge clk);
        set_req(0, 1'b1, LOG_SEL_LZC, 32'h0, 32'h0, 16'h0, 1'b0, 4'd3);
        #1 check("bp_rdy1", 32'(req_rdy), 32'd2);
        check_head("bp_h0", 0, 4'd1, 32'h00F0_F0F0, 2'b00);
        @(negedge clk);
        set_req(1, 1'b1, LOG_SEL_SEXT, 32'h0, 32'h0, 16'h8000, 1'b1, 4'd4);
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_stall_rdy", 32'(req_rdy), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check_head("bp_hold", 0, 4'd1, 32'h00F0_F0F0, 2'b00);
            @(negedge clk);
        end
        rslt_rdy = 1'b1;
        #1 check("bp_full_rdy", 32'(req_rdy), 32'd0);
        check_head("bp_rel", 0, 4'd1, 32'h00F0_F0F0, 2'b00);
        @(negedge clk);
        #1 check_head("bp_d1", 1, 4'd2, 32'h0000_000F, 2'b00);
        check("bp_rdy_r0", 32'(req_rdy), 32'd1);
        @(negedge clk);
        req_vld[0] = 1'b0;
        #1 check_head("bp_d2", 0, 4'd3, 32'hFFFF_FFFF, 2'b00);
        check("bp_rdy_r1", 32'(req_rdy), 32'd2);
        @(negedge clk);
        req_vld[1] = 1'b0;
        #1 check_head("bp_d3", 1, 4'd4, 32'hFFFF_8000, 2'b00);
        @(negedge clk);
        #1 check("bp_empty", 32'(rslt_vld), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);

        // Remaining selects
        do_single("or0", 0, LOG_SEL_OR,  32'h0, 32'h0, 16'h0, 1'b0, 4'd5, 32'h0, 2'b01);
        do_single("gen", 1, LOG_SEL_GEN, 32'h0, 32'h0, 16'h0, 1'b0, 4'd6, 32'h0000_0ABC, 2'b00);
        do_single("par", 0, LOG_SEL_PAR, 32'h0000_0007, 32'h0, 16'h0, 1'b0, 4'd7, 32'h1, 2'b00);
        do_single("imm", 1, LOG_SEL_AND, 32'hFFFF_FFFF, 32'h0, 16'h1234, 1'b1, 4'd8, 32'h0000_1234, 2'b00);

        // Async reset with two entries queued and ptr=1
        @(negedge clk);
        rslt_rdy = 1'b0;
        set_req(0, 1'b1, LOG_SEL_OR, 32'h1, 32'h2, 16'h0, 1'b0, 4'd9);
        @(negedge clk);
        @(negedge clk);
        req_vld = '0;
        #1 check_head("pre_rst", 0, 4'd9, 32'h3, 2'b00);
        rst_n = 1'b0;
        #1 check("arst_vld", 32'(rslt_vld), 32'd0);
        check("arst_rslt", rslt, 32'd0);
        check("arst_tag",  32'(rslt_tag), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rslt_rdy = 1'b1;
        set_req(0, 1'b1, LOG_SEL_AND, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 16'h0, 1'b0, 4'd3);
        set_req(1, 1'b1, LOG_SEL_XOR, 32'h0000_FFFF, 32'h00FF_00FF, 16'h0, 1'b0, 4'hA);
        #1 check("post_rst_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
        req_vld = '0;
        #1 check_head("post_rst", 0, 4'd3, 32'h00F0_F0F0, 2'b00);
        @(negedge clk);
        #1 check("final_empty", 32'(rslt_vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
